// File: rtl/pinball_input_ctrl_pkg.sv
// Shared encodings for the pinball input controller: game states, button indices,
// charge FSM states and the group-stepping helper.
package pinball_input_ctrl_pkg;

  localparam logic [2:0] GS_RESET = 3'd0;
  localparam logic [2:0] GS_WAIT  = 3'd1;
  localparam logic [2:0] GS_START = 3'd2;
  localparam logic [2:0] GS_GET   = 3'd3;
  localparam logic [2:0] GS_OVER  = 3'd4;

  localparam int NUM_BTN    = 5;
  localparam int BTN_UP     = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 2;
  localparam int BTN_LAUNCH = 3;
  localparam int BTN_CENTER = 4;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_CHARGE = 2'd1,
    CH_FIRE   = 2'd2
  } charge_state_e;

  // Simultaneous inc and dec cancel; 3-bit arithmetic gives the mod-8 wrap.
  function automatic logic [2:0] grp_step(logic [2:0] g, logic inc, logic dec);
    if (inc && !dec)      return g + 3'd1;
    else if (dec && !inc) return g - 3'd1;
    else                  return g;
  endfunction

endpackage

// File: rtl/pinball_input_ctrl_btn_debounce_onepulse.sv
// One button: 2-FF synchroniser, tick-sampled history, hysteretic level and
// a single-cycle pulse on each debounced rising edge.
module btn_debounce_onepulse #(
  parameter int DB_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
  output logic pulse
);

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic [DB_DEPTH-1:0] hist_q, hist_d;
  logic                level_q, level_d;
  logic                level_dly_q, level_dly_d;

  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    level_dly_d = level_q;
    hist_d      = hist_q;
    level_d     = level_q;
    if (tick) begin
      hist_d = {hist_q[DB_DEPTH-2:0], sync2_q};
      // Mixed history keeps the previous level.
      if (&hist_d)       level_d = 1'b1;
      else if (~|hist_d) level_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      hist_q      <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      hist_q      <= hist_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
    end
  end

  assign level = level_q;
  assign pulse = level_q & ~level_dly_q;

endmodule

// File: rtl/pinball_input_ctrl.sv
// Board buttons to game controls: debounce/one-pulse, target group select,
// start requests, gated flippers and the plunger charge/fire FSM.
module pinball_input_ctrl
  import pinball_input_ctrl_pkg::*;
#(
  parameter int DB_DIV     = 100_000,
  parameter int DB_DEPTH   = 4,
  parameter int CHARGE_DIV = 5_000_000,
  parameter int PWR_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       btn_raw,
  input  logic [2:0]       state,
  output logic [2:0]       selected_group,
  output logic             launch_pulse,
  output logic [PWR_W-1:0] launch_power,
  output logic             start_pulse,
  output logic             flipper_l,
  output logic             flipper_r
);

  localparam int TW = $clog2(DB_DIV);
  localparam int CW = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
  localparam logic [PWR_W-1:0] PWR_MAX = '1;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;

  always_comb begin
    tick       = (tick_cnt_q == TW'(DB_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

  logic [NUM_BTN-1:0] lvl, pls;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    btn_debounce_onepulse #(.DB_DEPTH(DB_DEPTH)) u_db (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .btn_raw(btn_raw[b]),
      .level  (lvl[b]),
      .pulse  (pls[b])
    );
  end

  // Up is debounced with the rest but has no consumer in this block yet.
  logic btn_unused;
  assign btn_unused = ^{lvl[BTN_UP], lvl[BTN_CENTER], pls[BTN_UP], pls[BTN_LAUNCH]};

  logic [2:0] group_q, group_d;
  logic       start_q, start_d;

  always_comb begin
    group_d = group_q;
    if (state == GS_RESET)
      group_d = 3'd0;
    else if (state == GS_WAIT)
      group_d = grp_step(group_q, pls[BTN_RIGHT], pls[BTN_LEFT]);
    start_d = pls[BTN_CENTER] && (state == GS_RESET || state == GS_OVER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      group_q <= 3'd0;
      start_q <= 1'b0;
    end else begin
      group_q <= group_d;
      start_q <= start_d;
    end
  end

  charge_state_e    ch_q;
  logic [CW-1:0]    div_q;
  logic [PWR_W-1:0] power_q;
  logic             launch_pulse_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_q           <= CH_IDLE;
      div_q          <= '0;
      power_q        <= '0;
      launch_pulse_q <= 1'b0;
    end else begin
      launch_pulse_q <= 1'b0;
      case (ch_q)
        CH_IDLE: begin
          // Level triggered: a launch already held on entering START charges at once.
          if (state == GS_START && lvl[BTN_LAUNCH]) begin
            ch_q    <= CH_CHARGE;
            power_q <= '0;
            div_q   <= '0;
          end
        end
        CH_CHARGE: begin
          if (state != GS_START) begin
            ch_q    <= CH_IDLE;
            power_q <= '0;
            div_q   <= '0;
          end else if (!lvl[BTN_LAUNCH]) begin
            ch_q           <= CH_FIRE;
            launch_pulse_q <= 1'b1;
          end else if (div_q == CW'(CHARGE_DIV - 1)) begin
            div_q <= '0;
            if (power_q != PWR_MAX) power_q <= power_q + PWR_W'(1);
          end else begin
            div_q <= div_q + CW'(1);
          end
        end
        CH_FIRE: ch_q <= CH_IDLE;
        default: ch_q <= CH_IDLE;
      endcase
    end
  end

  assign selected_group = group_q;
  assign start_pulse    = start_q;
  assign launch_pulse   = launch_pulse_q;
  assign launch_power   = power_q;
  assign flipper_l      = lvl[BTN_LEFT]  && (state == GS_START || state == GS_GET);
  assign flipper_r      = lvl[BTN_RIGHT] && (state == GS_START || state == GS_GET);

endmodule
